// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. It walks an active-low row strobe, debounces a single
// pressed key and its release, and emits one key_valid pulse for each physical press.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_sync,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    row_idx;
  logic [SW-1:0] dwell;
  logic [DW-1:0] cnt;
  logic [3:0]    pat;

  // A press is valid only when exactly one column is pulled low.
  function automatic logic single_low(input logic [3:0] c);
    logic [3:0] low;
    low = ~c;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [3:0] p);
    logic [1:0] c;
    logic [3:0] k;
    case (p)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      rows      <= 4'b1110;
      dwell     <= '0;
      cnt       <= '0;
      pat       <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Columns are sampled only at the end of the dwell so the lines have settled.
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (single_low(cols_sync)) begin
              pat   <= cols_sync;
              cnt   <= '0;
              state <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              rows    <= row_drive(row_idx + 2'd1);
            end
          end else begin
            dwell <= dwell + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (cols_sync != pat) begin
            dwell <= '0;
            state <= SCAN;
          end else if (cnt == DB_LAST) begin
            cnt       <= '0;
            key_code  <= key_lut(row_idx, pat);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        HELD: begin
          // A changed but still-pressed pattern (rolled finger) is not a new key.
          if (cols_sync == 4'hF) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (cols_sync != 4'hF) begin
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            cnt      <= '0;
            dwell    <= '0;
            key_held <= 1'b0;
            row_idx  <= row_idx + 2'd1;
            rows     <= row_drive(row_idx + 2'd1);
            state    <= SCAN;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner. It models a keypad whose pressed key closes one
// column only while its row is driven low.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols_sync;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_on = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;
  logic       multi = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cols_sync(cols_sync), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols_sync = 4'hF;
    if (multi && rows == 4'b1110) cols_sync = 4'b1100;
    else if (key_on && rows[key_row] == 1'b0) cols_sync = ~(4'b0001 << key_col);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rows !== 4'b1110) begin n_err++; $display("FAIL reset_rows got %b exp 1110", rows); end
    n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code got %h exp 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held got %b exp 0", key_held); end
  endtask

  task automatic test_scan_idle();
    logic [3:0] exp_rows;
    for (int i = 0; i <= 16; i++) begin
      exp_rows = ~(4'b0001 << ((i / 4) % 4));
      n_cmp++; if (rows !== exp_rows) begin n_err++; $display("FAIL scan_rows cyc %0d got %b exp %b", i, rows, exp_rows); end
      n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        n_err++; $display("FAIL scan_idle_out cyc %0d got v=%b h=%b exp 0 0", i, key_valid, key_held);
      end
      step();
    end
  endtask

  task automatic test_press6();
    key_row = 2'd1; key_col = 2'd2; key_on = 1'b1;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      n_cmp++; if (key_valid !== (i == 16)) begin n_err++; $display("FAIL press6_valid cyc %0d got %b exp %b", i, key_valid, (i == 16)); end
      if (i >= 8) begin
        n_cmp++; if (rows !== 4'b1101) begin n_err++; $display("FAIL press6_rows cyc %0d got %b exp 1101", i, rows); end
      end
      if (i < 16) step();
    end
    n_cmp++; if (key_code !== 4'h6) begin n_err++; $display("FAIL press6_code got %h exp 6", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press6_held got %b exp 1", key_held); end
    for (int i = 0; i < 24; i++) begin
      step();
      n_cmp++; if (rows !== 4'b1101 || key_held !== 1'b1 || key_valid !== 1'b0) begin
        n_err++; $display("FAIL press6_hold cyc %0d got rows=%b h=%b v=%b exp 1101 1 0", i, rows, key_held, key_valid);
      end
    end
  endtask

  task automatic test_release6();
    key_on = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_cmp++; if (key_held !== (i <= 8)) begin n_err++; $display("FAIL release_held cyc %0d got %b exp %b", i, key_held, (i <= 8)); end
      n_cmp++; if (rows !== ((i <= 8) ? 4'b1101 : 4'b1011)) begin n_err++; $display("FAIL release_rows cyc %0d got %b", i, rows); end
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL release_valid cyc %0d got %b exp 0", i, key_valid); end
    end
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL release_novalid cyc %0d got %b exp 0", i, key_valid); end
    end
  endtask

  task automatic test_bounce0();
    int pulses = 0;
    int first = -1;
    key_row = 2'd3; key_col = 2'd1;
    for (int i = 0; i < 30; i++) begin
      key_on = ((i / 3) % 2 == 0);
      step();
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid cyc %0d got %b exp 0", i, key_valid); end
    end
    key_on = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (key_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = j;
          n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL bounce_code got %h exp 0", key_code); end
        end
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL bounce_pulses got %0d exp 1", pulses); end
    n_cmp++; if (first < 9 || first > 25) begin n_err++; $display("FAIL bounce_latency got %0d exp 9..25", first); end
    key_on = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL bounce_release got %b exp 0", key_held); end
  endtask

  task automatic test_multi();
    bit seen_row3 = 0;
    multi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rows === 4'b0111) seen_row3 = 1;
      n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        n_err++; $display("FAIL multi_out cyc %0d got v=%b h=%b exp 0 0", i, key_valid, key_held);
      end
    end
    n_cmp++; if (!seen_row3) begin n_err++; $display("FAIL multi_scan got stalled exp row3 reached"); end
    multi = 1'b0;
  endtask

  task automatic test_held_bounce();
    bit got = 0;
    key_row = 2'd1; key_col = 2'd1; key_on = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (key_valid === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL hb_timeout got no key_valid exp pulse"); end
    n_cmp++; if (key_code !== 4'h5) begin n_err++; $display("FAIL hb_code got %h exp 5", key_code); end
    key_on = 1'b0;
    for (int i = 0; i < 5; i++) step();
    key_on = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin
        n_err++; $display("FAIL hb_hold cyc %0d got h=%b v=%b exp 1 0", i, key_held, key_valid);
      end
    end
    key_on = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL hb_release got %b exp 0", key_held); end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    key_row = 2'd0; key_col = 2'd0; key_on = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    n_cmp++; if (rows !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      n_err++; $display("FAIL rst_deb got rows=%b h=%b v=%b c=%h exp 1110 0 0 0", rows, key_held, key_valid, key_code);
    end
    reset = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (key_valid === 1'b1) got = 1;
    end
    n_cmp++; if (!got || key_code !== 4'h1) begin n_err++; $display("FAIL rst_press1 got v=%b c=%h exp 1 1", got, key_code); end
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    n_cmp++; if (rows !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      n_err++; $display("FAIL rst_held got rows=%b h=%b v=%b c=%h exp 1110 0 0 0", rows, key_held, key_valid, key_code);
    end
    reset = 1'b0;
    key_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_press6();
    test_release6();
    test_bounce0();
    test_multi();
    test_held_bounce();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
